// File: rtl/aes_key_schedule_gen_if.sv
// Round-key generator bus: the start/mode/key command plus the round-key output stream.
interface aes_key_schedule_gen_if;
  logic         start;
  logic [1:0]   mode;
  logic [255:0] key_in;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_data;
  logic [3:0]   rk_index;
  logic         rk_last;
  logic         err;

  modport master (
    output start, mode, key_in, rk_ready,
    input  busy, rk_valid, rk_data, rk_index, rk_last, err
  );

  modport slave (
    input  start, mode, key_in, rk_ready,
    output busy, rk_valid, rk_data, rk_index, rk_last, err
  );
endinterface

// File: rtl/aes_key_schedule_gen.sv
// Word-serial AES-128/192/256 key expansion. One schedule word is produced per
// step; every fourth word completes a round key, presented on a valid/ready
// stream with its round number and a last flag. An 8-word window holds the
// most recent Nk words: w[i-1] sits at slot 7, w[i-Nk] at slot 8-Nk.
module aes_key_schedule_gen #(
  parameter int MAX_NK   = 8,
  parameter int SBOX_LAT = 1
) (
  input logic                  clk,
  input logic                  rst,
  aes_key_schedule_gen_if.slave bus
);

  typedef enum logic [2:0] {IDLE, KEYW, GEN, SUBW, DONE} state_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Sbox as GF(2^8) inverse (a^254) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  state_t        state_q, state_d;
  logic [31:0]   win_q [8];
  logic [31:0]   grp_q [3];
  logic [5:0]    i_q;
  logic [2:0]    kc_q;
  logic [3:0]    nk_q, nr_q;
  logic [7:0]    rcon_q;
  logic [1:0]    lat_cnt_q;
  logic          rk_valid_q, rk_last_q, err_q;
  logic [127:0]  rk_data_q;
  logic [3:0]    rk_index_q;

  logic [3:0]    mode_nk, mode_nr;
  logic          mode_ok;
  logic [2:0]    old_idx;
  logic          need_sub, blocked, accept, last_word, lat_done;
  logic [31:0]   sub_in, sbox_comb, sub_res, temp, gen_word, wr_word;
  logic          do_wr, load_key, enter_sub, err_d;

  // Mode decode and legality of a requested key length.
  always_comb begin
    mode_nk = 4'd4;
    mode_nr = 4'd10;
    case (bus.mode)
      2'b01: begin mode_nk = 4'd6; mode_nr = 4'd12; end
      2'b10: begin mode_nk = 4'd8; mode_nr = 4'd14; end
      default: ;
    endcase
    mode_ok = (bus.mode != 2'b11) && (32'(mode_nk) <= 32'(MAX_NK));
  end

  assign old_idx   = 3'(4'd8 - nk_q);
  assign need_sub  = (kc_q == 3'd0) || ((nk_q == 4'd8) && (kc_q == 3'd4));
  assign sub_in    = (kc_q == 3'd0) ? {win_q[7][23:0], win_q[7][31:24]} : win_q[7];
  assign sbox_comb = subword(sub_in);
  assign temp      = need_sub ? (sub_res ^ {((kc_q == 3'd0) ? rcon_q : 8'h00), 24'h0})
                              : win_q[7];
  assign gen_word  = win_q[old_idx] ^ temp;
  assign blocked   = rk_valid_q & ~bus.rk_ready;
  assign accept    = rk_valid_q & bus.rk_ready;
  assign last_word = (i_q == {nr_q, 2'b11});
  assign lat_done  = ({30'd0, lat_cnt_q} + 32'd1) >= 32'(SBOX_LAT);

  generate
    if (SBOX_LAT == 0) begin : g_nolat
      assign sub_res = sbox_comb;
    end else begin : g_lat
      logic [31:0] pipe_q [SBOX_LAT];
      // Sbox read pipeline; its input is frozen while a sub word waits, so the tail holds the result.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int s = 0; s < SBOX_LAT; s++) pipe_q[s] <= '0;
        end else begin
          pipe_q[0] <= sbox_comb;
          for (int s = 1; s < SBOX_LAT; s++) pipe_q[s] <= pipe_q[s-1];
        end
      end
      assign sub_res = pipe_q[SBOX_LAT-1];
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and step strobes; no word is written while the output is blocked.
  always_comb begin
    state_d   = state_q;
    do_wr     = 1'b0;
    wr_word   = win_q[0];
    load_key  = 1'b0;
    enter_sub = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (mode_ok) begin
            load_key = 1'b1;
            state_d  = KEYW;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      KEYW: begin
        if (!blocked) begin
          do_wr = 1'b1;
          if ({1'b0, kc_q} == nk_q - 4'd1) state_d = GEN;
        end
      end
      GEN: begin
        wr_word = gen_word;
        if (need_sub && (SBOX_LAT != 0)) begin
          enter_sub = 1'b1;
          state_d   = SUBW;
        end else if (!blocked) begin
          do_wr = 1'b1;
          if (last_word) state_d = DONE;
        end
      end
      SUBW: begin
        wr_word = gen_word;
        if (lat_done && !blocked) begin
          do_wr   = 1'b1;
          state_d = last_word ? DONE : GEN;
        end
      end
      DONE: begin
        if (accept) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Window, counters, round-key assembly and the output stream registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < 8; j++) win_q[j] <= '0;
      for (int j = 0; j < 3; j++) grp_q[j] <= '0;
      i_q        <= '0;
      kc_q       <= '0;
      nk_q       <= 4'd4;
      nr_q       <= 4'd10;
      rcon_q     <= 8'h01;
      lat_cnt_q  <= '0;
      rk_valid_q <= 1'b0;
      rk_data_q  <= '0;
      rk_index_q <= '0;
      rk_last_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q <= err_d;
      if (load_key) begin
        // Key word j lands in slot j; Nk rotations during KEYW leave it in slot 8-Nk+j.
        for (int j = 0; j < 8; j++) win_q[j] <= bus.key_in[255-32*j -: 32];
        for (int j = 0; j < 3; j++) grp_q[j] <= '0;
        i_q    <= '0;
        kc_q   <= '0;
        nk_q   <= mode_nk;
        nr_q   <= mode_nr;
        rcon_q <= 8'h01;
      end
      if (enter_sub) lat_cnt_q <= '0;
      else if ((state_q == SUBW) && !lat_done) lat_cnt_q <= lat_cnt_q + 2'd1;
      if (do_wr) begin
        // In KEYW wr_word is slot 0, so this shift is a rotation of the key words.
        for (int j = 0; j < 7; j++) win_q[j] <= win_q[j+1];
        win_q[7] <= wr_word;
        i_q      <= i_q + 6'd1;
        kc_q     <= ({1'b0, kc_q} == nk_q - 4'd1) ? 3'd0 : kc_q + 3'd1;
        if ((state_q != KEYW) && (kc_q == 3'd0)) rcon_q <= xtime(rcon_q);
        if (i_q[1:0] == 2'b11) begin
          rk_data_q  <= {grp_q[0], grp_q[1], grp_q[2], wr_word};
          rk_valid_q <= 1'b1;
          rk_index_q <= i_q[5:2];
          rk_last_q  <= (i_q[5:2] == nr_q);
          for (int j = 0; j < 3; j++) grp_q[j] <= '0;
        end else begin
          case (i_q[1:0])
            2'd0:    grp_q[0] <= wr_word;
            2'd1:    grp_q[1] <= wr_word;
            2'd2:    grp_q[2] <= wr_word;
            default: ;
          endcase
          if (accept) rk_valid_q <= 1'b0;
        end
      end else if (accept) begin
        rk_valid_q <= 1'b0;
      end
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.rk_valid = rk_valid_q;
  assign bus.rk_data  = rk_data_q;
  assign bus.rk_index = rk_index_q;
  assign bus.rk_last  = rk_last_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_aes_key_schedule_gen.sv
// Directed bench for the AES key schedule generator: FIPS-197 vectors for all
// three key sizes, sbox latency variants, backpressure, error and reset cases.
module tb_aes_key_schedule_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes_key_schedule_gen_if bus ();
  aes_key_schedule_gen_if bus_l0 ();
  aes_key_schedule_gen_if bus_l2 ();
  aes_key_schedule_gen_if bus_n4 ();

  // Variant builds see the same command and ready as the main instance.
  assign bus_l0.start = bus.start;  assign bus_l0.mode = bus.mode;
  assign bus_l0.key_in = bus.key_in; assign bus_l0.rk_ready = bus.rk_ready;
  assign bus_l2.start = bus.start;  assign bus_l2.mode = bus.mode;
  assign bus_l2.key_in = bus.key_in; assign bus_l2.rk_ready = bus.rk_ready;
  assign bus_n4.start = bus.start;  assign bus_n4.mode = bus.mode;
  assign bus_n4.key_in = bus.key_in; assign bus_n4.rk_ready = bus.rk_ready;

  aes_key_schedule_gen #(.MAX_NK(8), .SBOX_LAT(1)) dut    (.clk(clk), .rst(rst), .bus(bus.slave));
  aes_key_schedule_gen #(.MAX_NK(8), .SBOX_LAT(0)) dut_l0 (.clk(clk), .rst(rst), .bus(bus_l0.slave));
  aes_key_schedule_gen #(.MAX_NK(8), .SBOX_LAT(2)) dut_l2 (.clk(clk), .rst(rst), .bus(bus_l2.slave));
  aes_key_schedule_gen #(.MAX_NK(4), .SBOX_LAT(1)) dut_n4 (.clk(clk), .rst(rst), .bus(bus_n4.slave));

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  logic [127:0] exp128 [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };
  localparam logic [127:0] EXP192_R0  = 128'h8e73b0f7da0e6452c810f32b809079e5;
  localparam logic [127:0] EXP192_R12 = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [127:0] EXP256_R0  = 128'h603deb1015ca71be2b73aef0857d7781;
  localparam logic [127:0] EXP256_R1  = 128'h1f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] EXP256_R14 = 128'hfe4890d1e6188d0b046df344706c631e;

  // Accepted keys as {last, index, data}.
  logic [132:0] q_main[$];
  logic [132:0] q_l0[$];
  logic [132:0] q_l2[$];
  int           stall_viol = 0;
  logic         held = 1'b0;
  logic [127:0] held_data;
  logic [3:0]   held_idx;

  // Records accepted keys and notes any change of a stalled key.
  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held && (!bus.rk_valid || bus.rk_data !== held_data || bus.rk_index !== held_idx))
        stall_viol++;
      held      = bus.rk_valid && !bus.rk_ready;
      held_data = bus.rk_data;
      held_idx  = bus.rk_index;
      if (bus.rk_valid && bus.rk_ready)
        q_main.push_back({bus.rk_last, bus.rk_index, bus.rk_data});
      if (bus_l0.rk_valid && bus_l0.rk_ready)
        q_l0.push_back({bus_l0.rk_last, bus_l0.rk_index, bus_l0.rk_data});
      if (bus_l2.rk_valid && bus_l2.rk_ready)
        q_l2.push_back({bus_l2.rk_last, bus_l2.rk_index, bus_l2.rk_data});
    end
  end

  function automatic logic any_busy();
    return bus.busy | bus_l0.busy | bus_l2.busy | bus_n4.busy;
  endfunction

  // Called #1 after a posedge; the next posedge is the start edge; returns #1 after it.
  task automatic start_op(input logic [1:0] m, input logic [255:0] k);
    bus.mode   = m;
    bus.key_in = k;
    bus.start  = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output logic timed_out);
    timed_out = 1'b1;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk);
      #1;
      if (!any_busy()) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.mode = 2'b00; bus.key_in = '0; bus.rk_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0)     begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.rk_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", bus.rk_valid); end
    n_cmp++; if (bus.rk_data !== 128'h0) begin n_bad++; $display("FAIL reset_data: got %h want 0", bus.rk_data); end
    n_cmp++; if (bus.rk_index !== 4'h0) begin n_bad++; $display("FAIL reset_index: got %h want 0", bus.rk_index); end
    n_cmp++; if (bus.rk_last !== 1'b0)  begin n_bad++; $display("FAIL reset_last: got %b want 0", bus.rk_last); end
    n_cmp++; if (bus.err !== 1'b0)      begin n_bad++; $display("FAIL reset_err: got %b want 0", bus.err); end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_aes128_latency();
    logic [132:0] e;
    q_main.delete();
    bus.rk_ready = 1'b1;
    start_op(2'b00, KEY128);
    for (int ed = 1; ed <= 55; ed++) begin
      @(posedge clk);
      #1;
      if (ed == 3) begin
        n_cmp++; if (bus.rk_valid !== 1'b0) begin n_bad++; $display("FAIL a128_early_valid: got %b want 0", bus.rk_valid); end
      end
      if (ed == 4) begin
        n_cmp++; if ({bus.rk_valid, bus.rk_index, bus.rk_data} !== {1'b1, 4'd0, exp128[0]}) begin
          n_bad++; $display("FAIL a128_round0: got %b/%0d/%h want 1/0/%h", bus.rk_valid, bus.rk_index, bus.rk_data, exp128[0]);
        end
      end
      if (ed == 53) begin
        n_cmp++; if (bus.rk_last !== 1'b0) begin n_bad++; $display("FAIL a128_last_early: got %b want 0", bus.rk_last); end
      end
      if (ed == 54) begin
        n_cmp++; if ({bus.rk_valid, bus.rk_last, bus.rk_index, bus.rk_data} !== {2'b11, 4'd10, exp128[10]}) begin
          n_bad++; $display("FAIL a128_round10: got %b%b/%0d/%h want 11/10/%h", bus.rk_valid, bus.rk_last, bus.rk_index, bus.rk_data, exp128[10]);
        end
      end
      if (ed == 55) begin
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL a128_busy_fall: got %b want 0", bus.busy); end
      end
    end
    n_cmp++; if (q_main.size() !== 11) begin n_bad++; $display("FAIL a128_count: got %0d want 11", q_main.size()); end
    for (int k = 0; k < 11 && k < q_main.size(); k++) begin
      e = {k == 10, 4'(k), exp128[k]};
      n_cmp++; if (q_main[k] !== e) begin n_bad++; $display("FAIL a128_key%0d: got %h want %h", k, q_main[k], e); end
    end
  endtask

  task automatic test_aes192();
    logic to;
    q_main.delete();
    bus.rk_ready = 1'b1;
    start_op(2'b01, KEY192);
    wait_idle(300, to);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL a192_timeout: got busy want idle"); end
    n_cmp++; if (q_main.size() !== 13) begin n_bad++; $display("FAIL a192_count: got %0d want 13", q_main.size()); end
    if (q_main.size() > 0) begin
      n_cmp++; if (q_main[0] !== {1'b0, 4'd0, EXP192_R0}) begin n_bad++; $display("FAIL a192_round0: got %h want %h", q_main[0], {1'b0, 4'd0, EXP192_R0}); end
      n_cmp++; if (q_main[q_main.size()-1] !== {1'b1, 4'd12, EXP192_R12}) begin
        n_bad++; $display("FAIL a192_round12: got %h want %h", q_main[q_main.size()-1], {1'b1, 4'd12, EXP192_R12});
      end
    end
  endtask

  task automatic test_aes256_latencies();
    logic to;
    q_main.delete(); q_l0.delete(); q_l2.delete();
    bus.rk_ready = 1'b1;
    start_op(2'b10, KEY256);
    wait_idle(300, to);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL a256_timeout: got busy want idle"); end
    n_cmp++; if (q_main.size() !== 15) begin n_bad++; $display("FAIL a256_count_lat1: got %0d want 15", q_main.size()); end
    n_cmp++; if (q_l0.size() !== 15)   begin n_bad++; $display("FAIL a256_count_lat0: got %0d want 15", q_l0.size()); end
    n_cmp++; if (q_l2.size() !== 15)   begin n_bad++; $display("FAIL a256_count_lat2: got %0d want 15", q_l2.size()); end
    if (q_main.size() == 15 && q_l0.size() == 15 && q_l2.size() == 15) begin
      for (int v = 0; v < 3; v++) begin
        logic [132:0] r0, r1, r14;
        r0  = (v == 0) ? q_main[0]  : (v == 1) ? q_l0[0]  : q_l2[0];
        r1  = (v == 0) ? q_main[1]  : (v == 1) ? q_l0[1]  : q_l2[1];
        r14 = (v == 0) ? q_main[14] : (v == 1) ? q_l0[14] : q_l2[14];
        n_cmp++; if (r0 !== {1'b0, 4'd0, EXP256_R0}) begin n_bad++; $display("FAIL a256_round0_v%0d: got %h want %h", v, r0, {1'b0, 4'd0, EXP256_R0}); end
        n_cmp++; if (r1 !== {1'b0, 4'd1, EXP256_R1}) begin n_bad++; $display("FAIL a256_round1_v%0d: got %h want %h", v, r1, {1'b0, 4'd1, EXP256_R1}); end
        n_cmp++; if (r14 !== {1'b1, 4'd14, EXP256_R14}) begin n_bad++; $display("FAIL a256_round14_v%0d: got %h want %h", v, r14, {1'b1, 4'd14, EXP256_R14}); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic to;
    logic [132:0] e;
    q_main.delete();
    stall_viol   = 0;
    bus.rk_ready = 1'b0;
    start_op(2'b00, KEY128);
    to = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk);
      #1;
      bus.rk_ready = 1'($urandom_range(0, 1));
      if (!any_busy()) begin
        to = 1'b0;
        break;
      end
    end
    bus.rk_ready = 1'b1;
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL bp_timeout: got busy want idle"); end
    n_cmp++; if (stall_viol !== 0) begin n_bad++; $display("FAIL bp_stable: got %0d changes while stalled want 0", stall_viol); end
    n_cmp++; if (q_main.size() !== 11) begin n_bad++; $display("FAIL bp_count: got %0d want 11", q_main.size()); end
    for (int k = 0; k < 11 && k < q_main.size(); k++) begin
      e = {k == 10, 4'(k), exp128[k]};
      n_cmp++; if (q_main[k] !== e) begin n_bad++; $display("FAIL bp_key%0d: got %h want %h", k, q_main[k], e); end
    end
  endtask

  task automatic test_err();
    logic to;
    bus.mode = 2'b11; bus.key_in = KEY256; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.err !== 1'b1)  begin n_bad++; $display("FAIL err_mode3_pulse: got %b want 1", bus.err); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL err_mode3_busy: got %b want 0", bus.busy); end
    @(negedge clk);
    n_cmp++; if (bus.err !== 1'b0)  begin n_bad++; $display("FAIL err_mode3_width: got %b want 0", bus.err); end
    @(posedge clk);
    #1;
    q_main.delete();
    start_op(2'b10, KEY256);
    @(negedge clk);
    n_cmp++; if (bus_n4.err !== 1'b1)  begin n_bad++; $display("FAIL err_nk4_pulse: got %b want 1", bus_n4.err); end
    n_cmp++; if (bus_n4.busy !== 1'b0) begin n_bad++; $display("FAIL err_nk4_busy: got %b want 0", bus_n4.busy); end
    n_cmp++; if ({bus.err, bus.busy} !== 2'b01) begin n_bad++; $display("FAIL err_legal_256: got err/busy %b want 01", {bus.err, bus.busy}); end
    @(posedge clk);
    #1;
    wait_idle(300, to);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL err_timeout: got busy want idle"); end
  endtask

  task automatic test_start_while_busy();
    logic to;
    q_main.delete();
    bus.rk_ready = 1'b1;
    start_op(2'b00, KEY128);
    repeat (10) @(posedge clk);
    #1;
    bus.mode = 2'b01; bus.key_in = KEY192; bus.start = 1'b1;
    repeat (5) @(posedge clk);
    #1 bus.start = 1'b0;
    wait_idle(300, to);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL swb_timeout: got busy want idle"); end
    n_cmp++; if (q_main.size() !== 11) begin n_bad++; $display("FAIL swb_count: got %0d want 11", q_main.size()); end
    if (q_main.size() > 0) begin
      n_cmp++; if (q_main[q_main.size()-1] !== {1'b1, 4'd10, exp128[10]}) begin
        n_bad++; $display("FAIL swb_last: got %h want %h", q_main[q_main.size()-1], {1'b1, 4'd10, exp128[10]});
      end
    end
  endtask

  task automatic test_reset_mid();
    logic to;
    logic [132:0] e;
    q_main.delete();
    bus.rk_ready = 1'b1;
    start_op(2'b00, KEY128);
    to = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (q_main.size() >= 4) begin
        to = 1'b0;
        break;
      end
    end
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL rstmid_round3: got %0d keys want 4", q_main.size()); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({bus.busy, bus.rk_valid, bus.rk_data, bus.rk_index, bus.rk_last, bus.err} !== 135'h0) begin
      n_bad++; $display("FAIL rstmid_outputs: got busy %b valid %b data %h idx %h last %b err %b want all 0",
                        bus.busy, bus.rk_valid, bus.rk_data, bus.rk_index, bus.rk_last, bus.err);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    q_main.delete();
    start_op(2'b00, KEY128);
    wait_idle(300, to);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL rstmid_timeout: got busy want idle"); end
    n_cmp++; if (q_main.size() !== 11) begin n_bad++; $display("FAIL rstmid_count: got %0d want 11", q_main.size()); end
    for (int k = 0; k < 11 && k < q_main.size(); k++) begin
      e = {k == 10, 4'(k), exp128[k]};
      n_cmp++; if (q_main[k] !== e) begin n_bad++; $display("FAIL rstmid_key%0d: got %h want %h", k, q_main[k], e); end
    end
  endtask

  initial begin
    test_reset();
    test_aes128_latency();
    test_aes192();
    test_aes256_latencies();
    test_backpressure();
    test_err();
    test_start_while_busy();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
